// File: rtl/zero_run_qualifier.sv
// Zero-run loss qualifier: declares loss after a run of all-zero samples and
// releases it after a run of nonzero samples, muting out_data while in loss.
module zero_run_qualifier #(
    parameter int WIDTH    = 8,
    parameter int ZERO_RUN = 16,
    parameter int NZ_RUN   = 4,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             loss,
    output logic             loss_set,
    output logic             loss_clr,
    output logic [CNT_W-1:0] zrun
);

    typedef enum logic {
        ACTIVE = 1'b0,
        LOSS   = 1'b1
    } state_t;

    // Thresholds compared one bit wider so run+1 cannot wrap at saturation.
    localparam logic [CNT_W:0] ZR_TH = (CNT_W+1)'(ZERO_RUN);
    localparam logic [CNT_W:0] NZ_TH = (CNT_W+1)'(NZ_RUN);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic run_reached(input logic [CNT_W-1:0] v,
                                         input logic [CNT_W:0]   th);
        return ({1'b0, v} + (CNT_W+1)'(1)) >= th;
    endfunction

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   zrun_q, zrun_d;
    logic [CNT_W-1:0]   nzrun_q, nzrun_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   out_data_q, out_data_d;
    logic               loss_set_q, loss_set_d;
    logic               loss_clr_q, loss_clr_d;

    logic accept;
    logic is_zero;

    assign accept  = in_valid & ~clear;
    assign is_zero = ~|in_data;

    always_comb begin
        state_d     = state_q;
        zrun_d      = zrun_q;
        nzrun_d     = nzrun_q;
        out_data_d  = out_data_q;
        out_valid_d = accept;
        loss_set_d  = 1'b0;
        loss_clr_d  = 1'b0;

        if (clear) begin
            state_d = ACTIVE;
            zrun_d  = '0;
            nzrun_d = '0;
        end else if (in_valid) begin
            if (is_zero) begin
                zrun_d  = sat_inc(zrun_q);
                nzrun_d = '0;
                if (state_q == ACTIVE && run_reached(zrun_q, ZR_TH)) begin
                    state_d    = LOSS;
                    loss_set_d = 1'b1;
                end
            end else begin
                zrun_d  = '0;
                nzrun_d = sat_inc(nzrun_q);
                if (state_q == LOSS && run_reached(nzrun_q, NZ_TH)) begin
                    state_d    = ACTIVE;
                    loss_clr_d = 1'b1;
                end
            end
            // Mute is decided by where this sample leaves the FSM.
            out_data_d = (state_d == LOSS) ? '0 : in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ACTIVE;
            zrun_q      <= '0;
            nzrun_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            loss_set_q  <= 1'b0;
            loss_clr_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            zrun_q      <= zrun_d;
            nzrun_q     <= nzrun_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            loss_set_q  <= loss_set_d;
            loss_clr_q  <= loss_clr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign loss      = (state_q == LOSS);
    assign loss_set  = loss_set_q;
    assign loss_clr  = loss_clr_q;
    assign zrun      = zrun_q;

endmodule
